simon_core_n: RTL

SIMON_CORE_N -- requirements
Module: simon_core_n

---
 rtl/simon_pkg.sv | 19 +
 rtl/simon_ms_tick.sv | 15 +
 rtl/simon_core_n.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared FSM encoding, LFSR constants and LOSE-tone timing for the Simon core.
package simon_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADD      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    WAIT_IN  = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int LOSE_TONE_MS = 8;
  localparam int LOSE_DUR_MS = 1000;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/simon_ms_tick.sv
// simon_ms_tick: millisecond prescaler, one-cycle tick every max(ticks_per_milli,1) clocks.
module simon_ms_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  output logic        tick
);
  logic [15:0] cnt, last;
  assign last = ticks_per_milli == 16'd0 ? 16'd0 : ticks_per_milli - 16'd1;
  // >= keeps the counter sane if ticks_per_milli shrinks mid-count
  assign tick = cnt >= last;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 16'd1;
endmodule

// File: rtl/simon_core_n.sv
// simon_core_n: Simon memory game core; define SIMON_TIMEOUT_EN to lose after TIMEOUT_MS without a press.
module simon_core_n
  import simon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MAX_LEN = 32,
  parameter int SHOW_MS = 400,
  parameter int GAP_MS = 200,
  parameter int TIMEOUT_MS = 3000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [15:0]                    ticks_per_milli,
  input  logic                           start,
  input  logic [NUM_CH-1:0]              btn,
  output logic [NUM_CH-1:0]              led,
  output logic                           sound,
  output logic [$clog2(MAX_LEN+1)-1:0]   score,
  output logic                           game_over
);
  localparam int CW = $clog2(NUM_CH);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int HALF = SHOW_MS / 2 > 0 ? SHOW_MS / 2 : 1;
  localparam int T1 = SHOW_MS > GAP_MS ? SHOW_MS : GAP_MS;
  localparam int T2 = T1 > TIMEOUT_MS ? T1 : TIMEOUT_MS;
  localparam int TW = $clog2((T2 > LOSE_DUR_MS ? T2 : LOSE_DUR_MS) + 1);

  logic              ms_tick;
  logic [NUM_CH:0]   s1, s2, s3, rise;
  logic [NUM_CH-1:0] brise;
  logic              start_rise, press, good, hit, lit, tone, led_on, pause, snd;
  logic [CW-1:0]     pch, cur, lch, led_ch;
  logic [CW-1:0]     seq [MAX_LEN];
  logic [15:0]       lfsr;
  logic [LW-1:0]     len, idx, score_q;
  logic [TW-1:0]     tmr, led_tmr;
  logic [3:0]        stmr, per;
  state_t            state;

  simon_ms_tick u_tick (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (ticks_per_milli),
    .tick            (ms_tick)
  );

  assign rise = s2 & ~s3;
  assign start_rise = rise[NUM_CH];
  assign brise = rise[NUM_CH-1:0];
  assign press = |brise;
  assign good = $onehot(brise);
  assign cur = seq[idx[IW-1:0]];
  assign hit = state == WAIT_IN && !pause && good && pch == cur;
  assign lit = state == SHOW_ON || (state == WAIT_IN && led_on);
  assign lch = state == SHOW_ON ? cur : led_ch;
  assign led = state == WIN ? '1 : lit ? NUM_CH'(1) << lch : '0;
  assign tone = lit || (state == LOSE && tmr < TW'(LOSE_DUR_MS));
  assign per = state == LOSE ? 4'(LOSE_TONE_MS) : 4'(lch) + 4'd1;
  assign sound = snd;
  assign score = score_q;
  assign game_over = state == WIN || state == LOSE;

  always_comb begin
    pch = '0;
    for (int i = 0; i < NUM_CH; i++) if (brise[i]) pch = CW'(i);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      lfsr <= LFSR_SEED;
    end else begin
      s1 <= {start, btn};
      s2 <= s1;
      s3 <= s2;
      lfsr <= lfsr_next(lfsr);
    end

  always_ff @(posedge clk)
    if (state == ADD) seq[len[IW-1:0]] <= lfsr[CW-1:0];

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      len <= '0;
      idx <= '0;
      score_q <= '0;
      tmr <= '0;
      pause <= 1'b0;
    end else begin
      // LOSE timer saturates so the tone window closes exactly once
      tmr <= (ms_tick && !(state == LOSE && tmr >= TW'(LOSE_DUR_MS))) ? tmr + TW'(1) : tmr;
      case (state)
        IDLE, WIN, LOSE:
          if (start_rise) begin
            state <= ADD;
            len <= '0;
            score_q <= '0;
          end
        ADD: begin
          len <= len + LW'(1);
          idx <= '0;
          tmr <= '0;
          state <= SHOW_ON;
        end
        SHOW_ON:
          if (ms_tick && tmr == TW'(SHOW_MS - 1)) begin
            tmr <= '0;
            state <= SHOW_OFF;
          end
        SHOW_OFF:
          if (ms_tick && tmr == TW'(GAP_MS - 1)) begin
            tmr <= '0;
            idx <= idx + LW'(1) < len ? idx + LW'(1) : '0;
            state <= idx + LW'(1) < len ? SHOW_ON : WAIT_IN;
            pause <= 1'b0;
          end
        WAIT_IN:
          if (pause) begin
            if (ms_tick && tmr == TW'(GAP_MS - 1)) state <= ADD;
          end else if (press) begin
            tmr <= '0;
            if (!hit) state <= LOSE;
            else if (idx + LW'(1) == len) begin
              score_q <= len;
              pause <= 1'b1;
              if (len == LW'(MAX_LEN)) state <= WIN;
            end else idx <= idx + LW'(1);
          end
`ifdef SIMON_TIMEOUT_EN
          else if (ms_tick && tmr == TW'(TIMEOUT_MS - 1)) begin
            tmr <= '0;
            state <= LOSE;
          end
`endif
        default: state <= IDLE;
      endcase
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      led_on <= 1'b0;
      led_ch <= '0;
      led_tmr <= '0;
    end else if (hit) begin
      led_on <= 1'b1;
      led_ch <= pch;
      led_tmr <= '0;
    end else if (state != WAIT_IN) led_on <= 1'b0;
    else if (led_on && ms_tick) begin
      led_on <= led_tmr != TW'(HALF - 1);
      led_tmr <= led_tmr + TW'(1);
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      snd <= 1'b0;
      stmr <= '0;
    end else if (!tone) begin
      snd <= 1'b0;
      stmr <= '0;
    end else if (ms_tick) begin
      snd <= stmr >= per - 4'd1 ? ~snd : snd;
      stmr <= stmr >= per - 4'd1 ? '0 : stmr + 4'd1;
    end
endmodule
